// File: rtl/sprite_line_fetch.sv
`default_nettype none
// ============================================================================
//  Module   : sprite_line_fetch
//  Purpose  : Fetches one scanline of the selected sprite-sheet frame from the
//             sprite ROM into a double-buffered line buffer. The pattern
//             generator reads pixels back by sprite-local x.
//  Options  : SPRITE_FETCH_FLIP_EN - when defined, facing_left mirrors the line
//  Revision : 1.0 - initial release
// ============================================================================
module sprite_line_fetch #(
  parameter int FRAME_W = 64,
  parameter int FRAME_H = 64,
  parameter int SHEET_W = 1024,
  parameter int PIX_W   = 4,
  parameter int ADDR_W  = 18
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [10:0]       frame_row,
  input  logic [10:0]       frame_col,
  input  logic [5:0]        max_width,
  input  logic              facing_left,
  input  logic [5:0]        line_y,
  input  logic              line_req,
  output logic              busy,
  output logic              line_done,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [PIX_W-1:0]  rom_data,
  input  logic [5:0]        px_x,
  output logic [PIX_W-1:0]  px_data,
  output logic              px_opaque
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t             r_state;
  logic               r_busy;
  logic               r_line_done;
  logic [ADDR_W-1:0]  r_rom_addr;
  logic [5:0]         r_x;
  logic [5:0]         r_w;
  logic               r_wr_en;
  logic [5:0]         r_wr_idx;
  logic               r_sel;
  logic [5:0]         r_front_w;
  logic               r_front_valid;
  logic [PIX_W-1:0]   r_px_data;
  logic               r_px_opaque;
  logic [PIX_W-1:0]   r_buf [2][FRAME_W];

  logic [ADDR_W-1:0]  w_base;
  logic [5:0]         w_wr_idx;
  logic [PIX_W-1:0]   w_rd;
  logic               w_opaque;

  // First ROM address of the requested line, taken straight from the inputs
  // in the latch cycle; later addresses are produced by incrementing.
  assign w_base = ADDR_W'((32'(frame_row) * 32'(FRAME_H) + 32'(line_y)) * 32'(SHEET_W)
                          + 32'(frame_col) * 32'(FRAME_W));

`ifdef SPRITE_FETCH_FLIP_EN
  logic r_flip;
  assign w_wr_idx = r_flip ? (r_w - 6'd1 - r_x) : r_x;
`else
  logic w_unused_facing;
  assign w_unused_facing = facing_left;
  assign w_wr_idx        = r_x;
`endif

  // Fetch sequencer: latch frame, walk x across the line, then swap buffers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= S_IDLE;
      r_busy        <= 1'b0;
      r_line_done   <= 1'b0;
      r_rom_addr    <= '0;
      r_x           <= 6'd0;
      r_w           <= 6'd0;
      r_wr_en       <= 1'b0;
      r_wr_idx      <= 6'd0;
      r_sel         <= 1'b0;
      r_front_w     <= 6'd0;
      r_front_valid <= 1'b0;
`ifdef SPRITE_FETCH_FLIP_EN
      r_flip        <= 1'b0;
`endif
    end else begin
      r_wr_en     <= 1'b0;
      r_line_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (line_req) begin
            r_w    <= max_width;
            r_x    <= 6'd0;
            r_busy <= 1'b1;
`ifdef SPRITE_FETCH_FLIP_EN
            r_flip <= facing_left;
`endif
            if (max_width != 6'd0) begin
              r_state    <= S_FETCH;
              r_rom_addr <= w_base;
            end else begin
              r_state     <= S_DONE;
              r_line_done <= 1'b1;
            end
          end
        end
        S_FETCH: begin
          // Data for the address on the bus now arrives next cycle.
          r_wr_en  <= 1'b1;
          r_wr_idx <= w_wr_idx;
          if (r_x == r_w - 6'd1) begin
            r_state <= S_DRAIN;
          end else begin
            r_x        <= r_x + 6'd1;
            r_rom_addr <= r_rom_addr + ADDR_W'(1);
          end
        end
        S_DRAIN: begin
          r_state     <= S_DONE;
          r_line_done <= 1'b1;
        end
        S_DONE: begin
          r_state       <= S_IDLE;
          r_busy        <= 1'b0;
          r_sel         <= ~r_sel;
          r_front_w     <= r_w;
          r_front_valid <= 1'b1;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Back-buffer write; the front buffer is never touched during a fetch.
  always_ff @(posedge clk) begin
    if (r_wr_en) begin
      r_buf[~r_sel][r_wr_idx] <= rom_data;
    end
  end

  assign w_rd     = r_buf[r_sel][px_x];
  assign w_opaque = r_front_valid && (px_x < r_front_w) && (w_rd != '0);

  // Registered pixel read; uses the pre-swap front buffer in the swap cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_px_data   <= '0;
      r_px_opaque <= 1'b0;
    end else begin
      r_px_opaque <= w_opaque;
      r_px_data   <= w_opaque ? w_rd : '0;
    end
  end

  assign busy      = r_busy;
  assign line_done = r_line_done;
  assign rom_addr  = r_rom_addr;
  assign px_data   = r_px_data;
  assign px_opaque = r_px_opaque;

endmodule
`default_nettype wire

// File: tb/tb_sprite_line_fetch.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sprite_line_fetch
//  Purpose  : Self-checking bench for sprite_line_fetch. A schedule-level
//             model predicts busy/line_done/rom_addr/pixel reads every cycle.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sprite_line_fetch;
  localparam int FRAME_W = 64;
  localparam int FRAME_H = 64;
  localparam int SHEET_W = 1024;
  localparam int PIX_W   = 4;
  localparam int ADDR_W  = 18;
`ifdef SPRITE_FETCH_FLIP_EN
  localparam bit FLIP = 1'b1;
`else
  localparam bit FLIP = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset;
  logic [10:0]       frame_row, frame_col;
  logic [5:0]        max_width, line_y, px_x;
  logic              facing_left, line_req;
  logic              busy, line_done, px_opaque;
  logic [ADDR_W-1:0] rom_addr;
  logic [PIX_W-1:0]  rom_data, px_data;

  sprite_line_fetch #(.FRAME_W(FRAME_W), .FRAME_H(FRAME_H), .SHEET_W(SHEET_W),
                      .PIX_W(PIX_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset), .frame_row(frame_row), .frame_col(frame_col),
    .max_width(max_width), .facing_left(facing_left), .line_y(line_y),
    .line_req(line_req), .busy(busy), .line_done(line_done), .rom_addr(rom_addr),
    .rom_data(rom_data), .px_x(px_x), .px_data(px_data), .px_opaque(px_opaque)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle=%0d actual=%0h expected=%0h", nm, cyc, act, exp);
    end
  endtask

  // ROM contents: plain low nibble for directed tests, a scrambled nibble later.
  bit rom_mode = 1'b0;
  function automatic logic [3:0] rom_fn(input logic [ADDR_W-1:0] a);
    return rom_mode ? (a[3:0] ^ a[9:6]) : a[3:0];
  endfunction
  always @(posedge clk) rom_data <= rom_fn(rom_addr);

  function automatic logic [ADDR_W-1:0] m_addr(input int row, input int y, input int col, input int off);
    longint v;
    v = (longint'(row) * FRAME_H + y) * SHEET_W + longint'(col) * FRAME_W + off;
    return v[ADDR_W-1:0];
  endfunction

  // ---------------- behavioural model: one accepted line as a time window ----
  int       m_start = -1000, m_done = -1000, m_W = 0;
  int       m_row, m_col, m_y;
  bit       m_flip, m_eb, m_fv = 1'b0;
  int       m_fw = 0;
  logic [3:0] m_front [64];
  logic [3:0] m_pend  [64];
  logic [3:0] e_pd = 4'h0;
  bit         e_po = 1'b0;

  always @(negedge clk) begin
    if (!reset) begin
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_line_done", 32'(line_done), 32'd0);
      chk("rst_rom_addr", 32'(rom_addr), 32'd0);
      chk("rst_px_data", 32'(px_data), 32'd0);
      chk("rst_px_opaque", 32'(px_opaque), 32'd0);
      m_fv = 1'b0; m_start = -1000; m_done = -1000; m_W = 0;
      e_pd = 4'h0; e_po = 1'b0;
    end else begin
      m_eb = (cyc > m_start) && (cyc <= m_done);
      chk("busy", 32'(busy), 32'(m_eb));
      chk("line_done", 32'(line_done), 32'(cyc == m_done));
      chk("px_data", 32'(px_data), 32'(e_pd));
      chk("px_opaque", 32'(px_opaque), 32'(e_po));
      if (m_W > 0 && cyc > m_start && cyc <= m_start + m_W)
        chk("rom_addr", 32'(rom_addr), 32'(m_addr(m_row, m_y, m_col, cyc - m_start - 1)));
      // Read sampled now is answered next cycle from the current front line.
      e_po = m_fv && (int'(px_x) < m_fw) && (m_front[px_x] != 4'h0);
      e_pd = e_po ? m_front[px_x] : 4'h0;
      if (cyc == m_done) begin
        m_front = m_pend; m_fw = m_W; m_fv = 1'b1;
      end
      if (line_req && !m_eb) begin
        m_start = cyc; m_W = int'(max_width);
        m_done  = cyc + ((m_W == 0) ? 1 : m_W + 2);
        m_row = int'(frame_row); m_col = int'(frame_col); m_y = int'(line_y);
        m_flip = FLIP && facing_left;
        for (int i = 0; i < 64; i++)
          m_pend[i] = (i < m_W) ? rom_fn(m_addr(m_row, m_y, m_col, m_flip ? (m_W - 1 - i) : i)) : 4'h0;
      end
    end
  end

  // ---------------- stimulus helpers ------------------------------------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic goto_cycle(input int c);
    while (cyc < c) tick();
  endtask

  task automatic req(input int row, input int col, input int y, input int w, input bit fl);
    frame_row = 11'(row); frame_col = 11'(col); line_y = 6'(y);
    max_width = 6'(w); facing_left = fl; line_req = 1'b1;
    tick();
    line_req = 1'b0;
  endtask

  task automatic wait_done(input int lim, output int dc);
    dc = -1;
    for (int k = 0; k < lim && dc < 0; k++) begin
      @(negedge clk);
      if (line_done === 1'b1) dc = cyc;
    end
    if (dc < 0) chk("line_done_timeout", 32'd0, 32'd1);
  endtask

  task automatic sweep();
    for (int i = 0; i < 64; i++) begin
      px_x = 6'(i); tick();
    end
    tick();
  endtask

  task automatic read_pin(input string nm, input int x, input int exp_d, input int exp_o);
    px_x = 6'(x); tick();
    @(negedge clk);
    chk({nm, "_data"}, 32'(px_data), 32'(exp_d));
    chk({nm, "_opaque"}, 32'(px_opaque), 32'(exp_o));
    tick();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog cycle=%0d actual=timeout expected=finish", cyc);
    $fatal(1);
  end

  int t0, dc;
  initial begin
    reset = 1'b0; line_req = 1'b0; frame_row = '0; frame_col = '0;
    max_width = '0; line_y = '0; facing_left = 1'b0; px_x = '0;
    repeat (3) tick();
    reset = 1'b1;
    tick();
    sweep();                                   // nothing fetched: all transparent

    // Directed line, then the same line mirrored.
    for (int fl = 0; fl < 2; fl++) begin
      t0 = cyc;
      req(1, 2, 5, 46, fl[0]);
      @(negedge clk);
      chk("addr_cycle1", 32'(rom_addr), 32'd70784);
      wait_done(100, dc);
      chk("done_at_48", 32'(dc - t0), 32'd48);
      tick();
      sweep();
      if (FLIP && fl == 1) begin
        read_pin("px0", 0, 13, 1);
        read_pin("px3", 3, 10, 1);
      end else begin
        read_pin("px0", 0, 0, 0);
        read_pin("px3", 3, 3, 1);
      end
      read_pin("px46", 46, 0, 0);
    end

    // Requests while busy are dropped; frame_col change after latch ignored.
    t0 = cyc;
    req(1, 2, 5, 46, 1'b0);
    goto_cycle(t0 + 2);  frame_col = 11'd7;
    goto_cycle(t0 + 5);  line_req = 1'b1; tick(); line_req = 1'b0;
    goto_cycle(t0 + 20); line_req = 1'b1; tick(); line_req = 1'b0;
    goto_cycle(t0 + 48);
    @(negedge clk);
    chk("busy_at_48", 32'(busy), 32'd1);
    chk("done_pulse_48", 32'(line_done), 32'd1);
    repeat (3) tick();

    // Reset in the middle of a fetch, then a normal fetch.
    t0 = cyc;
    req(3, 4, 9, 30, 1'b0);
    goto_cycle(t0 + 10);
    reset = 1'b0;
    @(negedge clk);
    chk("abort_busy", 32'(busy), 32'd0);
    tick(); tick();
    reset = 1'b1;
    tick();
    sweep();
    t0 = cyc;
    req(0, 5, 63, 20, 1'b1);
    wait_done(100, dc);
    chk("after_abort_done", 32'(dc - t0), 32'd22);
    tick();
    sweep();

    // Zero-width frame.
    t0 = cyc;
    req(2, 2, 2, 0, 1'b0);
    wait_done(10, dc);
    chk("w0_done_cycle1", 32'(dc - t0), 32'd1);
    tick();
    sweep();

    // Randomized traffic with mid-line input changes and occasional resets.
    rom_mode = 1'b1;
    for (int n = 0; n < 3000; n++) begin
      px_x        = 6'($urandom_range(0, 63));
      frame_row   = 11'($urandom);
      frame_col   = 11'($urandom);
      line_y      = 6'($urandom);
      max_width   = ($urandom_range(0, 7) == 0) ? 6'($urandom_range(0, 2)) : 6'($urandom);
      facing_left = 1'($urandom);
      line_req    = ($urandom_range(0, 9) == 0);
      reset       = ($urandom_range(0, 799) != 0);
      tick();
    end
    line_req = 1'b0; reset = 1'b1;
    repeat (80) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sprite_line_fetch.md
# sprite_line_fetch

Consumer side of the per-player animation selector: takes the selected sprite-sheet frame (`frame_row`, `frame_col`, `max_width`) and reads one scanline of that frame out of the sprite-sheet ROM into a double-buffered line buffer. The pattern generator reads pixels back by sprite-local x coordinate.

- Frame coordinates are latched per line, so an animation-state change mid-line cannot tear a sprite.
- Fetch for the next scanline overlaps display of the current one.

## Interface
Parameters:
- `FRAME_W`, 64: frame width in pixels; line buffer depth.
- `FRAME_H`, 64: frame height in pixels.
- `SHEET_W`, 1024: sprite-sheet width in pixels.
- `PIX_W`, 4: palette index width; index 0 is transparent.
- `ADDR_W`, 18: ROM address width.

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-low reset.
- `frame_row`  in  11  frame row index in sheet, from the animation selector.
- `frame_col`  in  11  frame column index in sheet.
- `max_width`  in  6  opaque width of the current frame in pixels.
- `facing_left`  in  1  mirror the line horizontally.
- `line_y`  in  6  sprite-local row to fetch, 0..FRAME_H-1.
- `line_req`  in  1  single-cycle request to fetch one line.
- `busy`  out  1  fetch in progress.
- `line_done`  out  1  single-cycle pulse; back buffer becomes the front buffer.
- `rom_addr`  out  ADDR_W  sprite ROM address.
- `rom_data`  in  PIX_W  ROM data, valid one cycle after `rom_addr`.
- `px_x`  in  6  read x within the front buffer.
- `px_data`  out  PIX_W  palette index at `px_x`.
- `px_opaque`  out  1  pixel is drawable.

## Operation
- FSM states: IDLE, FETCH, DRAIN, DONE.
- IDLE
  - `line_req`=1: latch all frame inputs, `x`=0. Go to FETCH if latched width W>0, else go to DONE.
- FETCH
  - `rom_addr` = (frame_row*FRAME_H + line_y)*SHEET_W + frame_col*FRAME_W + x, truncated to ADDR_W.
  - `x` increments each cycle.
  - After x=W-1, go to DRAIN.
- Writes
  - The write for address x lands one cycle after that address is issued, into the back buffer.
  - Write index is x, or W-1-x when mirrored.
- DRAIN: the final write lands; go to DONE.
- DONE: `line_done`=1, swap front/back, store W as front width, set `front_valid`; go to IDLE.
- `line_req` while `busy`: ignored, no queuing.
- Input changes after the latch cycle have no effect on the line in flight.
- Read port
  - `px_data` = front[px_x].
  - `px_opaque` = front_valid && px_x < front width && data≠0.
  - `px_data` is forced to 0 when `px_opaque`=0.
- Entries at index ≥ W in the back buffer are not written. They are masked by the width compare.

## Timing
- Reset values:
  - state IDLE, `busy`=0, `line_done`=0, `rom_addr`=0.
  - `px_data`=0, `px_opaque`=0.
  - `front_valid`=0, buffer select 0.
  - Buffer contents are undefined but masked by `front_valid`.
- `line_req` high in cycle 0, W>0:
  - FETCH in cycles 1..W.
  - DRAIN in cycle W+1.
  - `line_done` in cycle W+2.
  - New front buffer readable from cycle W+3.
  - `busy` is high cycles 1..W+2.
- W=0: `line_done` in cycle 1; the new front buffer reads all-transparent.
- Read latency: `px_x` sampled at cycle n gives `px_data`/`px_opaque` valid in cycle n+1.
- The front buffer is never written during a fetch, so reads are stable for the whole fetch.
- Swap and read in the same cycle: the read uses the pre-swap front buffer. The post-swap buffer is used from the next read.
- Reset asserted mid-fetch: aborts immediately. No `line_done`; `front_valid`=0.
- A `line_req` arriving in the same cycle as `line_done` is ignored. The earliest accepted request is the cycle after `line_done`.

## Configuration
- `SPRITE_FETCH_FLIP_EN` defined: `facing_left` is latched and mirrors the write index as above.
- Undefined: `facing_left` is ignored and the write index is always x. There is no mirror subtractor.

## Test plan
- Reset, then read px_x=0..63 -> `px_opaque`=0, `px_data`=0 everywhere. Issue no `line_req`.
- frame_row=1, frame_col=2, line_y=5, W=46, ROM pattern data=addr[3:0]:
  - `rom_addr` in cycle 1 = (64+5)*1024+128 = 70784, incrementing by 1.
  - `line_done` in cycle 48.
  - Reads match the pattern for x<46.
  - x≥46 reads transparent.
- Same line with facing_left=1 (flip enabled) -> px_x=0 returns the pixel fetched at x=45. Without the macro, px_x=0 returns the pixel fetched at x=0.
- `line_req` pulses at cycles 5 and 20 with W=46, and frame_col changed at cycle 2 -> one fetch only, using the latched frame_col. `busy` stays high through cycle 48.
- Reset asserted at cycle 10 of a fetch -> `busy`=0, no `line_done`, reads transparent. A new request completes normally.
- W=0 request -> `line_done` in cycle 1, no ROM addresses issued. All reads transparent.
